ping_pong_ctrl: RTL and testbench

//  Sequencer for the 4-bit Ping_Pong_Counter: drives its enable to run a programmed number of bounces.
//  A bounce is one change of the counter's direction output.
//  An optional pause is inserted after every bounce; the run finishes with a done pulse.

---
 rtl/ping_pong_pkg.sv | 13 +
 rtl/pp_pause_timer.sv | 27 ++
 rtl/ping_pong_ctrl.sv | 111 +++++++++++
 tb/tb_ping_pong_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ping_pong_pkg.sv
// rtl/ping_pong_pkg.sv - shared state encoding and counter constants for the ping-pong sequencer
package ping_pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'd15;

endpackage

// File: rtl/pp_pause_timer.sv
// rtl/pp_pause_timer.sv - loadable down-counter timing the post-bounce pause
module pp_pause_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Last cycle of the pause: the FSM re-enables on this edge.
  assign expire = (count == W'(1));

endmodule

// File: rtl/ping_pong_ctrl.sv
// rtl/ping_pong_ctrl.sv - sequences the ping-pong counter enable for a programmed number of bounces
module ping_pong_ctrl
  import ping_pong_pkg::*;
#(
  parameter int BW = 4,
  parameter int PW = 4
) (
  input  logic          CLK,
  input  logic          RESET_n,
  input  logic          start,
  input  logic          stop,
  input  logic [BW-1:0] bounce_target,
  input  logic [PW-1:0] pause_len,
  input  logic          direction,
  output logic          enable,
  output logic          busy,
  output logic          done,
  output logic [BW-1:0] bounce_cnt
);

  state_t        state;
  logic          dir_q;
  logic [BW-1:0] target_q;
  logic [PW-1:0] pause_q;
  logic [BW-1:0] cnt_inc;
  logic          bounce_ev;
  logic          cnt_last;
  logic          timer_load;
  logic          timer_expire;

  assign bounce_ev  = (state == RUN) && (direction != dir_q);
  assign cnt_inc    = bounce_cnt + 1'b1;
  assign cnt_last   = (cnt_inc == target_q);
  assign timer_load = bounce_ev && !stop && !cnt_last;

  pp_pause_timer #(.W(PW)) u_timer (
    .clk    (CLK),
    .rst_n  (RESET_n),
    .load   (timer_load),
    .val    (pause_q),
    .expire (timer_expire)
  );

  always_ff @(posedge CLK) begin
    dir_q <= direction;
    if (!RESET_n) begin
      state      <= IDLE;
      enable     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bounce_cnt <= '0;
      target_q   <= '0;
      pause_q    <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort wins over start, bounces and pause expiry; count is kept for inspection.
        state  <= IDLE;
        enable <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              target_q   <= bounce_target;
              pause_q    <= pause_len;
              bounce_cnt <= '0;
              if (bounce_target != '0) begin
                state  <= RUN;
                enable <= 1'b1;
                busy   <= 1'b1;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (bounce_ev) begin
              bounce_cnt <= cnt_inc;
              if (cnt_last) begin
                state  <= DONE;
                enable <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else if (pause_q != '0) begin
                state  <= PAUSE;
                enable <= 1'b0;
              end
            end
          end
          PAUSE: begin
            if (timer_expire) begin
              state  <= RUN;
              enable <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state  <= IDLE;
            enable <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// tb/tb_ping_pong_ctrl.sv - directed bench pairing ping_pong_ctrl with a behavioural ping-pong counter
module tb_ping_pong_ctrl;
  import ping_pong_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       stop;
  logic [3:0] bounce_target;
  logic [3:0] pause_len;
  logic       direction;
  logic       enable;
  logic       busy;
  logic       done;
  logic [3:0] bounce_cnt;
  logic [3:0] cnt_out;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int en_seen = 0;
  int cyc = 0;
  int zeros;
  bit frozen;

  always #5 clk = ~clk;

  ping_pong_ctrl #(.BW(4), .PW(4)) dut (
    .CLK           (clk),
    .RESET_n       (resetn),
    .start         (start),
    .stop          (stop),
    .bounce_target (bounce_target),
    .pause_len     (pause_len),
    .direction     (direction),
    .enable        (enable),
    .busy          (busy),
    .done          (done),
    .bounce_cnt    (bounce_cnt)
  );

  // Counter model: up to CNT_MAX, down to 0; direction flips on the turn-around step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_out   <= 4'd0;
      direction <= 1'b1;
    end else if (enable) begin
      if (direction) begin
        if (cnt_out == CNT_MAX) begin
          direction <= 1'b0;
          cnt_out   <= cnt_out - 4'd1;
        end else begin
          cnt_out <= cnt_out + 4'd1;
        end
      end else begin
        if (cnt_out == 4'd0) begin
          direction <= 1'b1;
          cnt_out   <= 4'd1;
        end else begin
          cnt_out <= cnt_out - 4'd1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (done === 1'b1) done_seen++;
    if (enable === 1'b1) en_seen++;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    bounce_target = 4'd0;
    pause_len = 4'd0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic run_start(input logic [3:0] t, input logic [3:0] p);
    bounce_target = t;
    pause_len = p;
    start = 1'b1;
    done_seen = 0;
    en_seen = 0;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) step();
    chk(tag, done, 1);
  endtask

  task automatic wait_cnt(input string tag, input logic [3:0] v, input int budget);
    for (int i = 0; i < budget && bounce_cnt !== v; i++) step();
    chk(tag, bounce_cnt, v);
  endtask

  initial begin
    // 1: reset values, and reset dominating a held start
    resetn = 1'b0;
    start = 1'b1;
    stop = 1'b0;
    bounce_target = 4'd2;
    pause_len = 4'd0;
    step();
    step();
    chk("rst_enable", enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", bounce_cnt, 0);
    step();
    chk("rst_start_busy", busy, 0);

    // 2: two bounces, no pause
    do_reset();
    run_start(4'd2, 4'd0);
    chk("t2_enable_first", enable, 1);
    chk("t2_busy_first", busy, 1);
    wait_done("t2_done_timeout", 100);
    chk("t2_elapsed", cyc, 33);
    chk("t2_cnt", bounce_cnt, 2);
    chk("t2_busy_at_done", busy, 0);
    chk("t2_out_overstep", cnt_out, 2);
    step();
    chk("t2_done_single", done, 0);
    repeat (3) step();
    chk("t2_out_frozen", cnt_out, 2);
    chk("t2_done_count", done_seen, 1);

    // 3a: target reached at first bounce, so no pause is taken
    do_reset();
    run_start(4'd1, 4'd3);
    wait_done("t3a_done_timeout", 100);
    chk("t3a_elapsed", cyc, 18);
    chk("t3a_en_cycles", en_seen, 17);
    chk("t3a_cnt", bounce_cnt, 1);
    chk("t3a_out", cnt_out, 13);

    // 3b: exactly three cycles of enable=0 after the first bounce
    do_reset();
    run_start(4'd2, 4'd3);
    wait_cnt("t3b_first_bounce", 4'd1, 100);
    zeros = 0;
    frozen = 1'b1;
    while (enable === 1'b0 && zeros < 20) begin
      zeros++;
      if (cnt_out !== 4'd13) frozen = 1'b0;
      step();
    end
    chk("t3b_pause_len", zeros, 3);
    chk("t3b_out_frozen", frozen, 1);
    step();
    chk("t3b_resume", cnt_out, 12);
    wait_done("t3b_done_timeout", 100);
    chk("t3b_elapsed", cyc, 36);
    chk("t3b_cnt", bounce_cnt, 2);
    chk("t3b_out", cnt_out, 2);

    // 4: stop during PAUSE
    do_reset();
    run_start(4'd3, 4'd5);
    wait_cnt("t4_first_bounce", 4'd1, 100);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_enable", enable, 0);
    chk("t4_cnt", bounce_cnt, 1);
    repeat (8) step();
    chk("t4_no_done", done_seen, 0);
    chk("t4_enable_idle", enable, 0);
    chk("t4_out_held", cnt_out, 13);

    // 5: start while busy ignored; start+stop in IDLE ignored; zero target
    do_reset();
    run_start(4'd2, 4'd0);
    repeat (5) step();
    bounce_target = 4'd1;
    pause_len = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t5_done_timeout", 100);
    chk("t5_elapsed", cyc, 33);
    chk("t5_cnt_latched", bounce_cnt, 2);
    step();
    bounce_target = 4'd3;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("t5_startstop_busy", busy, 0);
    chk("t5_startstop_enable", enable, 0);
    step();
    chk("t5_startstop_done", done, 0);
    run_start(4'd0, 4'd3);
    chk("t5_zero_done", done, 1);
    chk("t5_zero_busy", busy, 0);
    step();
    chk("t5_zero_done_end", done, 0);
    repeat (3) step();
    chk("t5_zero_never_enabled", en_seen, 0);
    chk("t5_zero_done_count", done_seen, 1);
    chk("t5_zero_cnt", bounce_cnt, 0);

    // 6: full-range target without wrap
    do_reset();
    run_start(4'd15, 4'd0);
    wait_done("t6_done_timeout", 1000);
    chk("t6_elapsed", cyc, 228);
    chk("t6_cnt", bounce_cnt, 15);
    chk("t6_out", cnt_out, 13);
    repeat (5) step();
    chk("t6_done_count", done_seen, 1);
    chk("t6_cnt_held", bounce_cnt, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
